// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: ALU opcodes,
// command opcodes, FSM state encoding and a small opcode classifier.
package alu_pkg;

    // Opcodes understood by the 4-bit combinational ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0110;
    localparam logic [3:0] ALU_ADD = 4'b1010;

    // Command opcodes presented on cmd_op.
    localparam logic [2:0] CMD_AND  = 3'b000;
    localparam logic [2:0] CMD_OR   = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_NOT  = 3'b011;
    localparam logic [2:0] CMD_ADD  = 3'b100;
    localparam logic [2:0] CMD_SUB  = 3'b101;
    localparam logic [2:0] CMD_ADC  = 3'b110;
    localparam logic [2:0] CMD_RSVD = 3'b111;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

    // True for commands whose carry chains between nibbles.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == CMD_ADD) || (op == CMD_SUB) || (op == CMD_ADC);
    endfunction

endpackage

// File: rtl/alu_seq_map.sv
// Maps the latched command opcode, the nibble position and the running carry
// onto the ALU control inputs. Everything is forced to zero outside EXEC.
module alu_seq_map
    import alu_pkg::*;
(
    input  logic       active,        // sequencer is in EXEC
    input  logic [2:0] op,            // latched command opcode
    input  logic       first,         // current nibble is nibble 0
    input  logic       carry_in_reg,  // carry out of the previous nibble
    input  logic       cin_q,         // latched cmd_cin (ADC only)
    output logic [3:0] alu_op,
    output logic       inv_b,         // SUB feeds the ALU with ~b
    output logic       alu_cin
);

    // Opcode translation and carry selection for the current nibble.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        alu_op  = 4'b0000;
        inv_b   = 1'b0;
        alu_cin = 1'b0;
        if (active) begin
            case (op)
                CMD_AND: alu_op = ALU_AND;
                CMD_OR:  alu_op = ALU_OR;
                CMD_XOR: alu_op = ALU_XOR;
                CMD_NOT: alu_op = ALU_NOT;
                CMD_ADD: begin
                    alu_op  = ALU_ADD;
                    alu_cin = first ? 1'b0 : carry_in_reg;
                end
                CMD_SUB: begin
                    alu_op  = ALU_ADD;
                    inv_b   = 1'b1;
                    alu_cin = first ? 1'b1 : carry_in_reg;
                end
                CMD_ADC: begin
                    alu_op  = ALU_ADD;
                    alu_cin = first ? cin_q : carry_in_reg;
                end
                default: alu_op = 4'b0000;  // reserved opcode never reaches EXEC
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial sequencer: accepts one wide command, drives the external
// 4-bit ALU once per clock from the low nibble upward while chaining the
// carry, then presents the assembled result and flags until consumed.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    input  logic                   cmd_cin,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_op,
    output logic                   alu_cin,
    input  logic [3:0]             alu_result,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic                   rsp_err
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q, b_q;
    logic             cin_q;
    logic [W-1:0]     result_q;
    logic             carry_q;
    logic             err_q;

    logic             in_exec;
    logic [3:0]       a_nib, b_nib;
    logic             inv_b;
    logic [3:0]       map_op;
    logic             map_cin;

    assign in_exec = (state_q == ST_EXEC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = (cmd_op == CMD_RSVD) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture and per-nibble result/carry accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand copies are reset along with the rest; they are a handful of flops, not a memory array.
            idx_q    <= '0;
            op_q     <= CMD_AND;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        idx_q    <= '0;
                        op_q     <= cmd_op;
                        a_q      <= cmd_a;
                        b_q      <= cmd_b;
                        cin_q    <= cmd_cin;
                        result_q <= '0;
                        carry_q  <= 1'b0;
                        err_q    <= (cmd_op == CMD_RSVD);
                    end
                end
                ST_EXEC: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            result_q[4*k +: 4] <= alu_result;
                        end
                    end
                    carry_q <= is_arith(op_q) ? alu_cout : 1'b0;
                    idx_q   <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Select the current operand nibbles from the latched operands.
    always_comb begin
        a_nib = 4'b0000;
        b_nib = 4'b0000;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
    end

    alu_seq_map u_map (
        .active       (in_exec),
        .op           (op_q),
        .first        (idx_q == '0),
        .carry_in_reg (carry_q),
        .cin_q        (cin_q),
        .alu_op       (map_op),
        .inv_b        (inv_b),
        .alu_cin      (map_cin)
    );

    assign alu_op  = map_op;
    assign alu_cin = map_cin;
    assign alu_a   = in_exec ? a_nib : 4'b0000;
    assign alu_b   = in_exec ? (inv_b ? ~b_nib : b_nib) : 4'b0000;

    // Response fields come straight from registers; zero is only meaningful while presenting.
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_err    = err_q;
    assign rsp_zero   = (state_q == ST_DONE) && (result_q == '0);

endmodule
